// File: rtl/bridge_1xn.sv
// CPU data-port bridge fanning one master out to N_SLV address-windowed slaves,
// with read-return steering and sticky logging of unmapped accesses.
module bridge_1xn #(
    parameter int                     N_SLV     = 2,
    parameter int                     XLEN      = 32,
    parameter logic [N_SLV*XLEN-1:0]  SLV_BASE  = {32'hBFAF0000, 32'h00000000},
    parameter logic [N_SLV*XLEN-1:0]  SLV_MASK  = {32'hFFFF0000, 32'hFFFFC000},
    parameter logic [XLEN-1:0]        MISS_DATA = 32'hDEADBEEF,
    parameter int                     REQ_PIPE  = 0,
    parameter int                     CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_data_en,
    input  logic [3:0]              cpu_data_wen,
    input  logic [XLEN-1:0]         cpu_data_addr,
    input  logic [XLEN-1:0]         cpu_data_wdata,
    output logic [XLEN-1:0]         cpu_data_rdata,
    output logic [N_SLV-1:0]        slv_en,
    output logic [4*N_SLV-1:0]      slv_wen,
    output logic [N_SLV*XLEN-1:0]   slv_addr,
    output logic [N_SLV*XLEN-1:0]   slv_wdata,
    input  logic [N_SLV*XLEN-1:0]   slv_rdata,
    input  logic                    err_clr,
    output logic                    err_valid,
    output logic [XLEN-1:0]         err_addr,
    output logic [CNT_W-1:0]        err_cnt
);

    logic            req_en;
    logic [3:0]      req_wen;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    generate
        if (REQ_PIPE != 0) begin : g_req_pipe
            logic            req_en_q,    req_en_d;
            logic [3:0]      req_wen_q,   req_wen_d;
            logic [XLEN-1:0] req_addr_q,  req_addr_d;
            logic [XLEN-1:0] req_wdata_q, req_wdata_d;

            always_comb begin
                req_en_d    = cpu_data_en;
                req_wen_d   = cpu_data_wen;
                req_addr_d  = cpu_data_addr;
                req_wdata_d = cpu_data_wdata;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    req_en_q    <= 1'b0;
                    req_wen_q   <= '0;
                    req_addr_q  <= '0;
                    req_wdata_q <= '0;
                end else begin
                    req_en_q    <= req_en_d;
                    req_wen_q   <= req_wen_d;
                    req_addr_q  <= req_addr_d;
                    req_wdata_q <= req_wdata_d;
                end
            end

            assign req_en    = req_en_q;
            assign req_wen   = req_wen_q;
            assign req_addr  = req_addr_q;
            assign req_wdata = req_wdata_q;
        end else begin : g_req_comb
            assign req_en    = cpu_data_en;
            assign req_wen   = cpu_data_wen;
            assign req_addr  = cpu_data_addr;
            assign req_wdata = cpu_data_wdata;
        end
    endgenerate

    logic [N_SLV-1:0] hit;
    logic             miss;

    // Scan from the top so the lowest matching window overwrites, keeping hit one-hot.
    always_comb begin
        hit = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (req_en && ((req_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN])) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
        miss = req_en && (hit == '0);
    end

    always_comb begin
        slv_en    = hit;
        slv_wen   = '0;
        slv_addr  = '0;
        slv_wdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            slv_wen[i*4 +: 4]      = hit[i] ? req_wen : 4'b0000;
            slv_addr[i*XLEN +: XLEN]  = req_addr;
            slv_wdata[i*XLEN +: XLEN] = req_wdata;
        end
    end

    logic [N_SLV-1:0] sel_q, sel_d;
    logic             miss_q, miss_d;

    always_comb begin
        sel_d  = hit;
        miss_d = miss;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            miss_q <= miss_d;
        end
    end

    // sel_q and miss_q are never both set, so the mux order does not matter.
    always_comb begin
        cpu_data_rdata = '0;
        if (miss_q) begin
            cpu_data_rdata = MISS_DATA;
        end
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                cpu_data_rdata = slv_rdata[i*XLEN +: XLEN];
            end
        end
    end

    logic             err_valid_q, err_valid_d;
    logic [XLEN-1:0]  err_addr_q,  err_addr_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

    // A miss overrides a simultaneous clear and restarts first-address capture.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_cnt_d   = err_cnt_q;
        if (miss) begin
            err_valid_d = 1'b1;
            if (!err_valid_q || err_clr) begin
                err_addr_d = req_addr;
            end
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bridge_1xn.sv
// Bench for bridge_1xn: three variants (default, registered request, 2-bit
// miss counter) driven in parallel and checked against a rule-level model.
module tb_bridge_1xn;

    logic        clk;
    logic        reset;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        err_clr;

    logic [31:0] rdata_w     [3];
    logic [1:0]  slv_en_w    [3];
    logic [7:0]  slv_wen_w   [3];
    logic [63:0] slv_addr_w  [3];
    logic [63:0] slv_wdata_w [3];
    logic [63:0] slv_rdata_w [3];
    logic        ev_w        [3];
    logic [31:0] ea_w        [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int n_chk = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bridge_1xn u0 (
        .clk(clk), .reset(reset), .cpu_data_en(cpu_en), .cpu_data_wen(cpu_wen),
        .cpu_data_addr(cpu_addr), .cpu_data_wdata(cpu_wdata), .cpu_data_rdata(rdata_w[0]),
        .slv_en(slv_en_w[0]), .slv_wen(slv_wen_w[0]), .slv_addr(slv_addr_w[0]),
        .slv_wdata(slv_wdata_w[0]), .slv_rdata(slv_rdata_w[0]), .err_clr(err_clr),
        .err_valid(ev_w[0]), .err_addr(ea_w[0]), .err_cnt(cnt0));

    bridge_1xn #(.REQ_PIPE(1)) u1 (
        .clk(clk), .reset(reset), .cpu_data_en(cpu_en), .cpu_data_wen(cpu_wen),
        .cpu_data_addr(cpu_addr), .cpu_data_wdata(cpu_wdata), .cpu_data_rdata(rdata_w[1]),
        .slv_en(slv_en_w[1]), .slv_wen(slv_wen_w[1]), .slv_addr(slv_addr_w[1]),
        .slv_wdata(slv_wdata_w[1]), .slv_rdata(slv_rdata_w[1]), .err_clr(err_clr),
        .err_valid(ev_w[1]), .err_addr(ea_w[1]), .err_cnt(cnt1));

    bridge_1xn #(.CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .cpu_data_en(cpu_en), .cpu_data_wen(cpu_wen),
        .cpu_data_addr(cpu_addr), .cpu_data_wdata(cpu_wdata), .cpu_data_rdata(rdata_w[2]),
        .slv_en(slv_en_w[2]), .slv_wen(slv_wen_w[2]), .slv_addr(slv_addr_w[2]),
        .slv_wdata(slv_wdata_w[2]), .slv_rdata(slv_rdata_w[2]), .err_clr(err_clr),
        .err_valid(ev_w[2]), .err_addr(ea_w[2]), .err_cnt(cnt2));

    // Slave content as a pure function of slave index and address.
    function automatic logic [31:0] sdata(input int k, input logic [31:0] a);
        if (k == 0 && a == 32'h0000_0010) return 32'h1122_3344;
        if (k == 0 && a == 32'h0000_0000) return 32'h0000_0001;
        if (k == 1 && a == 32'hBFAF_0008) return 32'h0000_0002;
        return a ^ (32'h5A00_0000 + 32'(k));
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'hBFAF_0000;
    endfunction

    function automatic logic [31:0] mask_of(input int k);
        return (k == 0) ? 32'hFFFF_C000 : 32'hFFFF_0000;
    endfunction

    // Slaves answer one cycle after being enabled, for reads and writes alike.
    always @(posedge clk) begin
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 2; k++)
                if (slv_en_w[j][k])
                    slv_rdata_w[j][k*32 +: 32] <= sdata(k, slv_addr_w[j][k*32 +: 32]);
    end

    task automatic chk(input string nm, input int j, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[u%0d]: got %0h expected %0h", nm, j, act, exp);
        end
    endtask

    function automatic logic [15:0] cnt_of(input int j);
        if (j == 0) return cnt0;
        if (j == 1) return cnt1;
        return {14'b0, cnt2};
    endfunction

    // Model state, one slot per variant.
    int          pipe_of [3] = '{0, 1, 0};
    int          cmax_of [3] = '{65535, 65535, 3};
    bit          armed = 1'b0;
    logic [31:0] m_rdata [3];
    bit          m_valid [3];
    logic [31:0] m_addr  [3];
    int          m_cnt   [3];
    bit          p_en    [3];
    logic [3:0]  p_wen   [3];
    logic [31:0] p_addr  [3];
    logic [31:0] p_wdata [3];

    bit          rq_en;
    logic [3:0]  rq_wen;
    logic [31:0] rq_addr, rq_wdata;
    int          k_hit;
    logic [1:0]  e_en;
    logic [7:0]  e_wen;

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            rq_en    = pipe_of[j] != 0 ? p_en[j]    : cpu_en;
            rq_wen   = pipe_of[j] != 0 ? p_wen[j]   : cpu_wen;
            rq_addr  = pipe_of[j] != 0 ? p_addr[j]  : cpu_addr;
            rq_wdata = pipe_of[j] != 0 ? p_wdata[j] : cpu_wdata;
            k_hit = -1;
            for (int k = 1; k >= 0; k--)
                if (rq_en && ((rq_addr & mask_of(k)) == base_of(k))) k_hit = k;
            e_en  = 2'b00;
            e_wen = 8'h00;
            if (k_hit >= 0) begin
                e_en[k_hit] = 1'b1;
                e_wen[k_hit*4 +: 4] = rq_wen;
            end
            if (armed) begin
                chk("slv_en",    j, 64'(slv_en_w[j]),  64'(e_en));
                chk("slv_wen",   j, 64'(slv_wen_w[j]), 64'(e_wen));
                chk("slv_addr",  j, slv_addr_w[j],     {rq_addr, rq_addr});
                chk("slv_wdata", j, slv_wdata_w[j],    {rq_wdata, rq_wdata});
                chk("rdata",     j, 64'(rdata_w[j]),   64'(m_rdata[j]));
                chk("err_valid", j, 64'(ev_w[j]),      64'(m_valid[j]));
                chk("err_addr",  j, 64'(ea_w[j]),      64'(m_addr[j]));
                chk("err_cnt",   j, 64'(cnt_of(j)),    64'(m_cnt[j]));
            end
            if (reset) begin
                m_rdata[j] = '0; m_valid[j] = 1'b0; m_addr[j] = '0; m_cnt[j] = 0;
                p_en[j] = 1'b0; p_wen[j] = '0; p_addr[j] = '0; p_wdata[j] = '0;
            end else begin
                if (k_hit >= 0)  m_rdata[j] = sdata(k_hit, rq_addr);
                else if (rq_en)  m_rdata[j] = 32'hDEAD_BEEF;
                else             m_rdata[j] = '0;
                if (rq_en && k_hit < 0) begin
                    if (!m_valid[j] || err_clr) m_addr[j] = rq_addr;
                    m_valid[j] = 1'b1;
                    if (m_cnt[j] < cmax_of[j]) m_cnt[j]++;
                end else if (err_clr) begin
                    m_valid[j] = 1'b0;
                end
                p_en[j] = cpu_en; p_wen[j] = cpu_wen; p_addr[j] = cpu_addr; p_wdata[j] = cpu_wdata;
            end
        end
        if (reset) armed = 1'b1;
    end

    task automatic drv(input bit rst, input bit en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit clr);
        @(posedge clk);
        #2;
        reset = rst; cpu_en = en; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; err_clr = clr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0; err_clr = 1'b0;
        drv(1, 0, 4'h0, 32'h0, 32'h0, 0);
        drv(1, 0, 4'h0, 32'h0, 32'h0, 0);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_rst_rdata", 0, 64'(rdata_w[0]), 64'h0);
        chk("lit_rst_valid", 0, 64'(ev_w[0]), 64'h0);
        chk("lit_rst_cnt",   0, 64'(cnt0), 64'h0);
        chk("lit_rst_en",    1, 64'(slv_en_w[1]), 64'h0);

        drv(0, 1, 4'h0, 32'h0000_0010, 32'h0, 0);
        chk("lit_rd_en", 0, 64'(slv_en_w[0]), 64'h1);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_rd_data",  0, 64'(rdata_w[0]), 64'h1122_3344);
        chk("lit_rd_valid", 0, 64'(ev_w[0]), 64'h0);
        chk("lit_rd_en_p",  1, 64'(slv_en_w[1]), 64'h1);

        drv(0, 1, 4'hF, 32'hBFAF_0004, 32'hA5A5_A5A5, 0);
        chk("lit_wr_en",    0, 64'(slv_en_w[0]), 64'h2);
        chk("lit_wr_wen",   0, 64'(slv_wen_w[0]), 64'hF0);
        chk("lit_wr_wdata", 0, 64'(slv_wdata_w[0][63:32]), 64'hA5A5_A5A5);
        chk("lit_rd_data_p", 1, 64'(rdata_w[1]), 64'h1122_3344);

        drv(0, 1, 4'h0, 32'h0000_0000, 32'h0, 0);
        drv(0, 1, 4'h0, 32'hBFAF_0008, 32'h0, 0);
        chk("lit_b2b_1", 0, 64'(rdata_w[0]), 64'h1);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_b2b_2",   0, 64'(rdata_w[0]), 64'h2);
        chk("lit_b2b_1_p", 1, 64'(rdata_w[1]), 64'h1);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_b2b_2_p", 1, 64'(rdata_w[1]), 64'h2);

        drv(0, 1, 4'h0, 32'h8000_0000, 32'h0, 0);
        drv(0, 1, 4'h0, 32'h9000_0000, 32'h0, 0);
        chk("lit_miss_data",  0, 64'(rdata_w[0]), 64'hDEAD_BEEF);
        chk("lit_miss_en",    0, 64'(slv_en_w[0]), 64'h0);
        chk("lit_miss_valid", 0, 64'(ev_w[0]), 64'h1);
        chk("lit_miss_addr",  0, 64'(ea_w[0]), 64'h8000_0000);
        drv(0, 1, 4'h0, 32'h7000_0000, 32'h0, 1);
        chk("lit_miss_data2", 0, 64'(rdata_w[0]), 64'hDEAD_BEEF);
        chk("lit_miss_cnt",   0, 64'(cnt0), 64'h2);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 1);
        chk("lit_clrmiss_valid", 0, 64'(ev_w[0]), 64'h1);
        chk("lit_clrmiss_addr",  0, 64'(ea_w[0]), 64'h7000_0000);
        chk("lit_clrmiss_cnt",   0, 64'(cnt0), 64'h3);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_clr_valid", 0, 64'(ev_w[0]), 64'h0);
        chk("lit_clr_cnt",   0, 64'(cnt0), 64'h3);
        chk("lit_clr_addr",  0, 64'(ea_w[0]), 64'h7000_0000);

        drv(1, 0, 4'h0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 5; i++)
            drv(0, 1, (i == 2) ? 4'hF : 4'h0, 32'hC000_0000 + 32'(i * 16), 32'h1234_5678, 0);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_sat_cnt",  2, 64'(cnt2), 64'h3);
        chk("lit_wide_cnt", 0, 64'(cnt0), 64'h5);
        chk("lit_sat_addr", 0, 64'(ea_w[0]), 64'hC000_0000);

        drv(0, 1, 4'h0, 32'h0000_0010, 32'h0, 0);
        drv(1, 1, 4'h0, 32'hBFAF_0008, 32'h0, 0);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_mrst_rdata",   0, 64'(rdata_w[0]), 64'h0);
        chk("lit_mrst_cnt",     0, 64'(cnt0), 64'h0);
        chk("lit_mrst_rdata_p", 1, 64'(rdata_w[1]), 64'h0);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("lit_mrst_rdata_p2", 1, 64'(rdata_w[1]), 64'h0);
        drv(0, 0, 4'h0, 32'h0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bridge_1xn.md
Name: bridge_1xn

Overview:
- Parametrised successor of the 1-to-2 data-side bridge: routes the CPU data port to N_SLV slaves using per-slave base/mask address windows.
- Tracks the outstanding read to steer returned data, and optionally registers the request path.
- Detects unmapped accesses: returns MISS_DATA, logs the first offending address and counts misses.
- Sits between cpu_pipeline's data port and the data sram, confreg and future peripherals.

Parameters:
N_SLV, 2, number of slave channels (1..8)
XLEN, 32, address/data width
SLV_BASE, {32'hBFAF0000, 32'h00000000}, packed N_SLV*XLEN base addresses; slave i at bits [i*XLEN +: XLEN]
SLV_MASK, {32'hFFFF0000, 32'hFFFFC000}, packed N_SLV*XLEN masks, same packing as SLV_BASE
MISS_DATA, 32'hDEADBEEF, read data returned for an unmapped read
REQ_PIPE, 0, 0 = combinational request path; 1 = request registered one cycle
CNT_W, 16, width of the miss counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
cpu_data_en  input  1  CPU access enable
cpu_data_wen  input  4  byte write enables; 0 = read
cpu_data_addr  input  XLEN  byte address
cpu_data_wdata  input  XLEN  write data
cpu_data_rdata  output  XLEN  read data
slv_en  output  N_SLV  per-slave enable
slv_wen  output  4*N_SLV  per-slave byte enables
slv_addr  output  N_SLV*XLEN  per-slave address (full address, unmodified)
slv_wdata  output  N_SLV*XLEN  per-slave write data
slv_rdata  input  N_SLV*XLEN  per-slave read data, valid one cycle after slv_en
err_clr  input  1  clears err_valid
err_valid  output  1  sticky unmapped-access flag
err_addr  output  XLEN  address of the first miss since the last clear
err_cnt  output  CNT_W  saturating count of misses

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high; all state below is reset by it.
- Decode:
  - hit_i = req_en & ((req_addr & MASK_i) == BASE_i).
  - Overlapping windows: the lowest index wins, so the select is one-hot.
  - miss = req_en & no hit.
- Request path:
  - REQ_PIPE=0: req_* = cpu_data_*.
  - REQ_PIPE=1: req_* are registered copies of cpu_data_*. Reset value of req_en is 0.
- Slave outputs:
  - slv_en[i] = hit_i.
  - slv_wen[i] = hit_i ? req_wen : 0.
  - slv_addr and slv_wdata broadcast req_addr and req_wdata to all slaves.
  - On a miss, no slave is enabled and the write is discarded.
- Read return:
  - sel_q (N_SLV one-hot) and miss_q update every cycle: sel_q <= hit vector, miss_q <= miss.
  - cpu_data_rdata = slave rdata of the sel_q slave when sel_q != 0; MISS_DATA if miss_q; else 0.
  - CPU-visible read latency is 1 cycle (REQ_PIPE=0) or 2 cycles (REQ_PIPE=1).
  - Back-to-back accesses to different slaves are allowed every cycle; rdata follows each one in order.
- Error logging:
  - On miss: err_valid <= 1.
  - err_addr <= req_addr only if err_valid was 0 (first miss is kept).
  - err_cnt increments and saturates at all-ones.
  - err_clr & !miss: err_valid <= 0; err_addr and err_cnt are held.
  - err_clr & miss in the same cycle: the miss wins; err_valid stays 1 and err_addr captures the new address.
  - err_cnt is cleared only by reset.
- Reset values: err_valid 0, err_addr 0, err_cnt 0, sel_q 0, miss_q 0, cpu_data_rdata 0, slv_en 0 (REQ_PIPE=1; combinational otherwise).
- Reset mid-operation: any outstanding read return is dropped; the cycle after reset, rdata is 0.

Test Plan:
- Read at 0x00000010, slave0 returns 0x11223344 -> slv_en=2'b01; the next cycle rdata=0x11223344; err_valid stays 0.
- Write 0xBFAF0004, wen=4'hF, wdata=0xA5A5A5A5 -> slv_en=2'b10, slv_wen[7:4]=4'hF, slv_wdata[63:32]=0xA5A5A5A5; slave0 wen=0.
- Back-to-back reads 0x00000000 then 0xBFAF0008 (slave data 0x1, 0x2) -> rdata 0x1 then 0x2 on consecutive cycles; with REQ_PIPE=1 the same sequence arrives one cycle later.
- Reads to 0x80000000, then 0x90000000 -> slv_en=0; rdata=0xDEADBEEF each; err_valid=1, err_addr=0x80000000, err_cnt=2.
- err_clr asserted in the same cycle as a miss at 0x70000000 after the previous step -> err_valid=1, err_addr=0x70000000, err_cnt=3; err_clr alone next cycle -> err_valid=0, err_cnt=3.
- CNT_W=2: five misses -> err_cnt saturates at 3.
- Reset asserted during an outstanding read -> rdata=0 and err_cnt=0 the next cycle.
